// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester single-port SRAM arbiter with bus lock and read-return.
// Ports: clk/n_rst (sync, active-low); req/lock/wen/addr/wdat per requester;
// gnt one-hot grant; rvalid/rdat read return; sram_* drive the synchronous SRAM.
// Optional: define SRAM_ARB_STALL_CNT_EN to add a saturating 16-bit stall_cnt output.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [1:0]              req,
  input  logic [1:0]              lock,
  input  logic [1:0]              wen,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdat,
  output logic [1:0]              gnt,
  output logic [1:0]              rvalid,
  output logic [DATA_WIDTH-1:0]   rdat,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic                    sram_wen,
  output logic                    sram_ren,
  output logic [DATA_WIDTH-1:0]   sram_wdat,
`ifdef SRAM_ARB_STALL_CNT_EN
  output logic [15:0]             stall_cnt,
`endif
  input  logic [DATA_WIDTH-1:0]   sram_rdat
);
  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;
  // The grant cycle in ARB is the first locked cycle, so release fires once
  // cnt reaches LOCK_MAX-1 inside the lock state.
  localparam logic [7:0] LIM = 8'(LOCK_MAX - 1);
  state_t     state, nstate;
  logic       last, nlast;
  logic [7:0] cnt, ncnt;
  logic [1:0] rd_q;
  always_comb begin
    gnt    = 2'b00;
    nstate = state;
    nlast  = last;
    ncnt   = cnt;
    case (state)
      ARB: begin
        gnt = req == 2'b11 ? (last ? 2'b01 : 2'b10) : req;
        if (|(gnt & lock)) begin
          nstate = gnt[0] ? LOCK0 : LOCK1;
          ncnt   = 8'd1;
        end
      end
      LOCK0: begin
        gnt  = {1'b0, req[0]};
        ncnt = cnt + 8'd1;
        if (!lock[0] || cnt >= LIM) nstate = ARB;
      end
      LOCK1: begin
        gnt  = {req[1], 1'b0};
        ncnt = cnt + 8'd1;
        if (!lock[1] || cnt >= LIM) nstate = ARB;
      end
      default: nstate = ARB;
    endcase
    if (!n_rst) gnt = 2'b00;
    if (|gnt) nlast = gnt[1];
    // Leaving a lock hands the next tie to the other requester even if the
    // holder dropped req in its final cycle.
    if (state == LOCK0 && nstate == ARB) nlast = 1'b0;
    if (state == LOCK1 && nstate == ARB) nlast = 1'b1;
  end
  assign sram_addr = gnt[1] ? addr[ADDR_WIDTH +: ADDR_WIDTH] : gnt[0] ? addr[0 +: ADDR_WIDTH] : '0;
  assign sram_wdat = gnt[1] ? wdat[DATA_WIDTH +: DATA_WIDTH] : gnt[0] ? wdat[0 +: DATA_WIDTH] : '0;
  assign sram_wen  = |(gnt & wen);
  assign sram_ren  = |(gnt & ~wen);
  assign rvalid    = rd_q;
  assign rdat      = |rd_q ? sram_rdat : '0;
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= ARB;
      last  <= 1'b1;
      cnt   <= 8'd0;
      rd_q  <= 2'b00;
    end else begin
      state <= nstate;
      last  <= nlast;
      cnt   <= ncnt;
      rd_q  <= gnt & ~wen;
    end
  end
`ifdef SRAM_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!n_rst) stall_cnt <= 16'd0;
    else if (|(req & ~gnt) && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: table-driven and hand-sequenced checks of sram_arbiter with an SRAM model and read scoreboard.
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int DW = 32;
  logic          clk = 1'b0;
  logic          n_rst;
  logic [1:0]    req, lock, wen;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdat;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdat, sram_wdat, sram_rdat;
  logic [AW-1:0] sram_addr;
  logic          sram_wen, sram_ren;
`ifdef SRAM_ARB_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif
  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(16)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .lock(lock), .wen(wen), .addr(addr), .wdat(wdat),
    .gnt(gnt), .rvalid(rvalid), .rdat(rdat), .sram_addr(sram_addr), .sram_wen(sram_wen),
    .sram_ren(sram_ren), .sram_wdat(sram_wdat),
`ifdef SRAM_ARB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .sram_rdat(sram_rdat));
  always #5 clk = ~clk;
  logic          mem_clr;
  logic [DW-1:0] mem [256];
  logic [255:0]  mem_wr;
  always @(posedge clk) begin
    if (mem_clr) mem_wr <= '0;
    else begin
      if (sram_wen) begin
        mem[sram_addr[7:0]]    <= sram_wdat;
        mem_wr[sram_addr[7:0]] <= 1'b1;
      end
      if (sram_ren) sram_rdat <= mem_wr[sram_addr[7:0]] ? mem[sram_addr[7:0]] : {24'hA5A5A5, sram_addr[7:0]};
    end
  end
  logic [DW-1:0] ref_mem [256];
  logic [255:0]  ref_wr;
  typedef struct packed { logic [1:0] v; logic [DW-1:0] d; } rsp_t;
  rsp_t sb [$];
  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic step(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                      input logic [7:0] a0, input logic [7:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic [1:0] eg, input string nm);
    logic [7:0] ea;
    logic [DW-1:0] ed;
    rsp_t e, got;
    req = r; lock = l; wen = w;
    addr = {AW'(a1), AW'(a0)};
    wdat = {d1, d0};
    #2;
    ea = eg[1] ? a1 : eg[0] ? a0 : 8'd0;
    ed = eg[1] ? d1 : eg[0] ? d0 : '0;
    chk({nm, " gnt"}, 64'(gnt), 64'(eg));
    chk({nm, " sram"}, {sram_wen, sram_ren, sram_addr, sram_wdat},
        {|(eg & w), |(eg & ~w), AW'(ea), ed});
    e.v = eg & ~w;
    e.d = |e.v ? (ref_wr[ea] ? ref_mem[ea] : {24'hA5A5A5, ea}) : '0;
    if (|(eg & w)) begin
      ref_mem[ea] = ed;
      ref_wr[ea]  = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({nm, " rsp"}, 64'({rvalid, rdat}), 64'({got.v, got.d}));
  endtask
  typedef struct {
    logic [1:0] r, l, w;
    logic [7:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [1:0] eg;
  } vec_t;
  vec_t tbl [12];
  initial begin
    tbl[0]  = '{2'b11, 2'b00, 2'b00, 8'h05, 8'h09, 0, 0, 2'b01};
    tbl[1]  = '{2'b11, 2'b00, 2'b00, 8'h05, 8'h09, 0, 0, 2'b10};
    tbl[2]  = '{2'b11, 2'b00, 2'b00, 8'h05, 8'h09, 0, 0, 2'b01};
    tbl[3]  = '{2'b11, 2'b00, 2'b00, 8'h05, 8'h09, 0, 0, 2'b10};
    tbl[4]  = '{2'b01, 2'b00, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF, 0, 2'b01};
    tbl[5]  = '{2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 0, 0, 2'b01};
    tbl[6]  = '{2'b10, 2'b00, 2'b10, 8'h00, 8'h20, 0, 32'h12345678, 2'b10};
    tbl[7]  = '{2'b11, 2'b00, 2'b00, 8'h20, 8'h10, 0, 0, 2'b01};
    tbl[8]  = '{2'b11, 2'b00, 2'b00, 8'h20, 8'h10, 0, 0, 2'b10};
    tbl[9]  = '{2'b00, 2'b00, 2'b00, 8'h01, 8'h02, 0, 0, 2'b00};
    tbl[10] = '{2'b10, 2'b00, 2'b00, 8'h00, 8'h07, 0, 0, 2'b10};
    tbl[11] = '{2'b11, 2'b00, 2'b00, 8'h06, 8'h07, 0, 0, 2'b01};
    ref_wr = '0;
    mem_clr = 1'b1;
    n_rst = 1'b0;
    req = 2'b00; lock = 2'b00; wen = 2'b00; addr = '0; wdat = '0;
    @(posedge clk);
    #1;
    mem_clr = 1'b0;
    step(2'b11, 2'b00, 2'b00, 8'h05, 8'h09, 0, 0, 2'b00, "in_reset");
`ifdef SRAM_ARB_STALL_CNT_EN
    chk("stall_reset", 64'(stall_cnt), 64'd0);
`endif
    n_rst = 1'b1;
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].l, tbl[i].w, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, tbl[i].eg,
           $sformatf("vec%0d", i));
`ifdef SRAM_ARB_STALL_CNT_EN
      if (i == 3) chk("stall_contend", 64'(stall_cnt), 64'd4);
`endif
    end
    for (int i = 1; i <= 20; i++)
      step(2'b11, 2'b10, 2'b00, 8'h03, 8'h04, 0, 0, i == 17 ? 2'b01 : 2'b10, $sformatf("lockmax%0d", i));
    step(2'b11, 2'b00, 2'b00, 8'h03, 8'h04, 0, 0, 2'b10, "lock1_exit");
    step(2'b11, 2'b01, 2'b00, 8'h03, 8'h04, 0, 0, 2'b01, "lock0_c1");
    step(2'b11, 2'b01, 2'b00, 8'h03, 8'h04, 0, 0, 2'b01, "lock0_c2");
    step(2'b11, 2'b00, 2'b00, 8'h03, 8'h04, 0, 0, 2'b01, "lock0_c3");
    step(2'b11, 2'b00, 2'b00, 8'h03, 8'h04, 0, 0, 2'b10, "lock0_after");
    step(2'b01, 2'b00, 2'b00, 8'h05, 8'h00, 0, 0, 2'b01, "pre_reset_rd");
    n_rst = 1'b0;
    step(2'b01, 2'b00, 2'b00, 8'h05, 8'h00, 0, 0, 2'b00, "reset_rd");
    step(2'b11, 2'b00, 2'b11, 8'h05, 8'h09, 1, 2, 2'b00, "reset_wr");
`ifdef SRAM_ARB_STALL_CNT_EN
    chk("stall_after_reset", 64'(stall_cnt), 64'd0);
`endif
    n_rst = 1'b1;
    step(2'b11, 2'b00, 2'b00, 8'h05, 8'h09, 0, 0, 2'b01, "post_reset_tie");
    step(2'b11, 2'b00, 2'b00, 8'h05, 8'h09, 0, 0, 2'b10, "post_reset_alt");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
